// File: rtl/md_hazard_ctrl.sv
// md_hazard_ctrl
// Stall/flush controller for the five-stage MIPS pipeline (F/D/E/M/W).
// Detects hazards that forwarding cannot cover (Tuse < Tnew). It also sequences
// the multi-cycle mult/div unit with a busy counter. It drives the PC and D
// register write-enables and the E register clear.
//
// Optional feature macro: STALL_CNT_EN. When it is defined, the block adds two
// saturating counters: stall_cycles and md_stall_cycles.
//
// Ports:
//   clk             in   1   clock, all state updates on posedge
//   reset           in   1   synchronous, active-high
//   instr_d         in  32   instruction in D register
//   instr_e         in  32   instruction in E register
//   instr_m         in  32   instruction in M register
//   pc_en           out  1   PC write enable (0 = hold)
//   d_en            out  1   D register write enable (0 = hold)
//   e_clr           out  1   synchronous clear of E register (bubble)
//   md_start        out  1   one-cycle start pulse to mult/div unit
//   md_busy         out  1   mult/div unit occupied
//   md_cnt          out  4   remaining busy cycles
//   stall_cycles    out 32   (STALL_CNT_EN) cycles with stall asserted
//   md_stall_cycles out 32   (STALL_CNT_EN) cycles with md_stall asserted
module md_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [31:0] instr_e,
  input  logic [31:0] instr_m,
  output logic        pc_en,
  output logic        d_en,
  output logic        e_clr,
  output logic        md_start,
  output logic        md_busy,
  output logic [3:0]  md_cnt
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles
`endif
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  // Source-operand usage of an instruction in D, packed as
  // {rs_used, rs_tuse[1:0], rt_used, rt_tuse[1:0]}.
  function automatic logic [5:0] src_use(input logic [31:0] ins);
    logic [5:0] r;
    r = 6'b0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h21, 6'h23,
          6'h18, 6'h19, 6'h1A, 6'h1B: r = {1'b1, 2'd1, 1'b1, 2'd1};
          6'h08:                      r = {1'b1, 2'd0, 1'b0, 2'd0};
          6'h11, 6'h13:               r = {1'b1, 2'd1, 1'b0, 2'd0};
          default:                    r = 6'b0;
        endcase
      end
      6'h0D, 6'h23: r = {1'b1, 2'd1, 1'b0, 2'd0};
      6'h2B:        r = {1'b1, 2'd1, 1'b1, 2'd2};
      6'h04:        r = {1'b1, 2'd0, 1'b1, 2'd0};
      default:      r = 6'b0;
    endcase
    return r;
  endfunction

  // Destination register; 0 stands for "no write", which also never stalls.
  function automatic logic [4:0] dest_of(input logic [31:0] ins);
    logic [4:0] r;
    r = 5'd0;
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h21 || ins[5:0] == 6'h23 ||
            ins[5:0] == 6'h10 || ins[5:0] == 6'h12)
          r = ins[15:11];
      end
      6'h0D, 6'h0F, 6'h23: r = ins[20:16];
      6'h03:               r = 5'd31;
      default:             r = 5'd0;
    endcase
    return r;
  endfunction

  // Cycles until the result is ready for forwarding, seen from the E stage.
  function automatic logic [1:0] tnew_e_of(input logic [31:0] ins);
    logic [1:0] r;
    r = 2'd0;
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h21 || ins[5:0] == 6'h23 ||
            ins[5:0] == 6'h10 || ins[5:0] == 6'h12)
          r = 2'd1;
      end
      6'h0D, 6'h0F: r = 2'd1;
      6'h23:        r = 2'd2;
      default:      r = 2'd0;
    endcase
    return r;
  endfunction

  // Any instruction that touches HI/LO must wait for the unit.
  function automatic logic is_md_class(input logic [31:0] ins);
    return (ins[31:26] == 6'h00) &&
           ((ins[5:2] == 4'b0110) || (ins[5:2] == 4'b0100));
  endfunction

  // A 1-bit stall request when stage X writes a register that D reads too early.
  function automatic logic hit(input logic [5:0] src, input logic [31:0] ins_d,
                               input logic [4:0] dest, input logic [1:0] tnew);
    return (dest != 5'd0) &&
           ((src[5] && (ins_d[25:21] == dest) && (src[4:3] < tnew)) ||
            (src[2] && (ins_d[20:16] == dest) && (src[1:0] < tnew)));
  endfunction

  logic [5:0] src_d;
  logic [4:0] dest_e;
  logic [4:0] dest_m;
  logic [1:0] tnew_e;
  logic [1:0] tnew_m;
  logic       e_is_md_op;
  logic       e_is_div;
  logic       hz_stall;
  logic       md_stall;
  logic       stall;

  always_comb begin
    src_d      = src_use(instr_d);
    dest_e     = dest_of(instr_e);
    dest_m     = dest_of(instr_m);
    tnew_e     = tnew_e_of(instr_e);
    // Only lw still has a cycle to go once it reaches M.
    tnew_m     = {1'b0, (instr_m[31:26] == 6'h23)};
    e_is_md_op = (instr_e[31:26] == 6'h00) && (instr_e[5:2] == 4'b0110);
    e_is_div   = instr_e[1];
    hz_stall   = hit(src_d, instr_d, dest_e, tnew_e) ||
                 hit(src_d, instr_d, dest_m, tnew_m);
    // The start gating on md_cnt is a safety net.
    // Md instructions are held in D while the unit is busy.
    md_start   = e_is_md_op && (md_cnt == 4'd0);
    md_busy    = (md_cnt != 4'd0);
    md_stall   = is_md_class(instr_d) && (md_start || md_busy);
    stall      = hz_stall || md_stall;
    pc_en      = ~stall;
    d_en       = ~stall;
    e_clr      = stall;
  end

  // The busy window spans the start cycle plus the loaded count.
  always_ff @(posedge clk) begin
    if (reset)
      md_cnt <= 4'd0;
    else if (md_start)
      md_cnt <= e_is_div ? DIV_LOAD : MULT_LOAD;
    else if (md_cnt != 4'd0)
      md_cnt <= md_cnt - 4'd1;
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles    <= 32'd0;
      md_stall_cycles <= 32'd0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (md_stall && (md_stall_cycles != 32'hFFFF_FFFF))
        md_stall_cycles <= md_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/md_hazard_ctrl.md
Name: md_hazard_ctrl

Overview:
Stall/flush controller for the five-stage MIPS pipeline (F/D/E/M/W pipeline registers).
- Detects load-use and branch-operand hazards that forwarding cannot cover, using Tuse/Tnew comparison.
- Sequences the multi-cycle multiply/divide unit with a busy counter.
- Drives the write-enables of PC and the D register and the clear of the E register, freezing F/D and inserting a bubble into E.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start (1..15)
DIV_CYCLES, 10, busy cycles after a div/divu start (1..15)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high; clock clk
instr_d  in  32  instruction in D register
instr_e  in  32  instruction in E register
instr_m  in  32  instruction in M register
pc_en  out  1  PC write enable (0 = hold)
d_en  out  1  D pipeline register write enable (0 = hold)
e_clr  out  1  synchronous clear of E register (load nop)
md_start  out  1  one-cycle start pulse to mult/div unit
md_busy  out  1  mult/div unit occupied
md_cnt  out  4  remaining busy cycles

Behaviour:
- Supported decode set (standard MIPS encodings): addu, subu, ori, lui, lw, sw, beq, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo. Any other opcode, including nop, has no Tuse and no write.
- Tuse(rs):
  - beq, jr = 0
  - addu, subu, ori, lw, sw, mult*, div*, mthi, mtlo = 1
- Tuse(rt):
  - beq = 0
  - addu, subu, mult*, div* = 1
  - sw = 2
- Destination:
  - rd for addu, subu, mfhi, mflo
  - rt for ori, lui, lw
  - 31 for jal
  - none otherwise
- Tnew in E:
  - lw = 2
  - addu, subu, ori, lui, mfhi, mflo = 1
  - jal = 0
- Tnew in M: lw = 1, others 0.
- hz_stall = 1 when a stage X in {E, M} with dest != 0 matches an rs/rt used by instr_d and Tuse < Tnew_X. Register 0 never stalls.
- md class = mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
- md_start = 1 when instr_e is mult/multu/div/divu and md_cnt == 0; combinational.
- md_cnt update (posedge):
  - reset → 0
  - else md_start → MULT_CYCLES or DIV_CYCLES
  - else if md_cnt != 0 → md_cnt - 1
  - No wrap below 0.
- md_busy = (md_cnt != 0).
- md_stall = instr_d is md class AND (md_start OR md_busy).
- stall = hz_stall OR md_stall.
- Outputs: pc_en = d_en = ~stall; e_clr = stall.
- Simultaneous hazard and md stall: a single stall, identical outputs.
- A start while busy cannot occur, because md instructions are held in D. md_start is still gated by md_cnt == 0.
- Reset mid-operation: md_cnt clears on that edge. From the next cycle md_busy = 0. Outputs are then purely a function of the instr inputs.
- Reset values: md_cnt = 0, md_busy = 0. With all instr = 0: pc_en = d_en = 1, e_clr = 0, md_start = 0.
- Latency:
  - Hazard outputs are combinational (same cycle).
  - The busy window covers the start cycle plus the N following cycles.

Optional Feature:
STALL_CNT_EN
- Defined:
  - Adds output stall_cycles [31:0], reset to 0.
  - Increments by 1 on each posedge where stall = 1, saturating at 0xFFFFFFFF.
  - Adds output md_stall_cycles [31:0], same rule, counting md_stall only.
- Undefined: neither port nor counter exists; all other behaviour identical.

Test Plan:
- Load-use: instr_e = 0x8C010000 (lw $1,0($0)), instr_d = 0x00211021 (addu $2,$1,$1) → pc_en = 0, d_en = 0, e_clr = 1. Next cycle with the lw in M and a bubble in E → stall = 0.
- Branch: instr_e = 0x34010005 (ori $1,$0,5), instr_d = 0x10210003 (beq $1,$1) → stall = 1. Same with the ori in M → stall = 0. Same with dest $0 → never stalls.
- Store-data: instr_e = 0x8C010000 (lw $1), instr_d = 0xAC010004 (sw $1,4($0)) → stall = 0 (Tuse 2 = Tnew 2). instr_m = lw $1 → stall = 0.
- Mult: instr_e = 0x00220018 (mult $1,$2), instr_d = 0x00001812 (mflo $3) → md_start = 1 and stall = 1 that cycle. md_cnt then reads 5,4,3,2,1; stall persists. md_cnt = 0 → stall = 0. Total 6 stalled cycles.
- Div: 0x0022001A (div) in E, instr_d = addu (non-md) → md_start = 1, stall = 0, md_busy = 1 for 10 cycles.
- Reset while md_cnt = 3 → md_cnt = 0, md_busy = 0 after the edge; mflo in D no longer stalls. Under STALL_CNT_EN, stall_cycles reads 0.
